// File: rtl/ldm_seq.sv
// ldm_seq: expands one LDM/STM into single-register transfer beats plus an optional base-writeback beat.
// Latency: 1 cycle from the i_start sample to the first registered beat; one beat per cycle with i_en high.
// Backpressure: i_en low holds state, remaining list and all outputs; i_flush aborts to IDLE with outputs cleared.
//
// Ports: clk/rst (sync, active-high); i_en advance enable; i_flush abort; i_start + i_load/i_pre/i_up/i_wb,
//        i_rn_code, i_reg_list describe the instruction; o_busy stalls fetch/decode; o_vld/o_load/o_rd_code/
//        o_offset/o_last form a transfer beat; o_wb_vld/o_wb_rd_code/o_wb_offset form the writeback beat;
//        o_pc_load flags an LDM beat targeting R15.
// Build option: define LDM_SEQ_PCLOAD_EN to build the R15 load detection; otherwise o_pc_load is tied to 0.
module ldm_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_flush,
  input  logic        i_start,
  input  logic        i_load,
  input  logic        i_pre,
  input  logic        i_up,
  input  logic        i_wb,
  input  logic [3:0]  i_rn_code,
  input  logic [15:0] i_reg_list,
  output logic        o_busy,
  output logic        o_vld,
  output logic        o_load,
  output logic [3:0]  o_rd_code,
  output logic [7:0]  o_offset,
  output logic        o_last,
  output logic        o_wb_vld,
  output logic [3:0]  o_wb_rd_code,
  output logic [7:0]  o_wb_offset,
  output logic        o_pc_load
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB} state_t;

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;            // registers not yet presented
  logic        cmd_load_q, cmd_load_d;
  logic        cmd_wb_q, cmd_wb_d;
  logic [3:0]  cmd_rn_q, cmd_rn_d;
  logic [7:0]  cmd_delta_q, cmd_delta_d; // signed writeback delta

  logic        busy_q, busy_d;
  logic        vld_q, vld_d;
  logic        load_q, load_d;
  logic [3:0]  rd_q, rd_d;
  logic [7:0]  offset_q, offset_d;
  logic        last_q, last_d;
  logic        wb_vld_q, wb_vld_d;
  logic [3:0]  wb_rd_q, wb_rd_d;
  logic [7:0]  wb_off_q, wb_off_d;

  logic [15:0] beat_src;
  logic [15:0] beat_rem;
  logic [3:0]  beat_rd;
  logic [4:0]  n_in;
  logic [7:0]  n4;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cmd_load_d  = cmd_load_q;
    cmd_wb_d    = cmd_wb_q;
    cmd_rn_d    = cmd_rn_q;
    cmd_delta_d = cmd_delta_q;
    vld_d       = vld_q;
    load_d      = load_q;
    rd_d        = rd_q;
    offset_d    = offset_q;
    last_d      = last_q;
    wb_vld_d    = wb_vld_q;
    wb_rd_d     = wb_rd_q;
    wb_off_d    = wb_off_q;

    // In IDLE the first beat is taken straight from the incoming list.
    beat_src = (state_q == S_IDLE) ? i_reg_list : rem_q;
    beat_rd  = lowest_set(beat_src);
    beat_rem = beat_src & (beat_src - 16'd1);  // clears the lowest set bit
    n_in     = popcnt16(i_reg_list);
    n4       = {1'b0, n_in, 2'b00};

    if (i_flush || i_en) begin
      vld_d    = 1'b0;
      load_d   = 1'b0;
      rd_d     = '0;
      offset_d = '0;
      last_d   = 1'b0;
      wb_vld_d = 1'b0;
      wb_rd_d  = '0;
      wb_off_d = '0;
    end

    if (i_flush) begin
      state_d = S_IDLE;
    end else if (i_en) begin
      case (state_q)
        S_IDLE: begin
          if (i_start && (n_in != 5'd0)) begin
            cmd_load_d  = i_load;
            // An LDM that reloads its own base keeps the loaded value.
            cmd_wb_d    = i_wb && !(i_load && i_reg_list[i_rn_code]);
            cmd_rn_d    = i_rn_code;
            cmd_delta_d = i_up ? n4 : (8'd0 - n4);
            case ({i_pre, i_up})
              2'b01:   offset_d = 8'd0;        // IA
              2'b11:   offset_d = 8'd4;        // IB
              2'b00:   offset_d = 8'd4 - n4;   // DA
              default: offset_d = 8'd0 - n4;   // DB
            endcase
            vld_d   = 1'b1;
            load_d  = i_load;
            rd_d    = beat_rd;
            last_d  = (beat_rem == 16'd0);
            rem_d   = beat_rem;
            state_d = S_XFER;
          end
        end
        S_XFER: begin
          if (last_q) begin
            if (cmd_wb_q) begin
              wb_vld_d = 1'b1;
              wb_rd_d  = cmd_rn_q;
              wb_off_d = cmd_delta_q;
              state_d  = S_WB;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            vld_d    = 1'b1;
            load_d   = cmd_load_q;
            rd_d     = beat_rd;
            offset_d = offset_q + 8'd4;
            last_d   = (beat_rem == 16'd0);
            rem_d    = beat_rem;
          end
        end
        S_WB:    state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      cmd_load_q  <= 1'b0;
      cmd_wb_q    <= 1'b0;
      cmd_rn_q    <= '0;
      cmd_delta_q <= '0;
      busy_q      <= 1'b0;
      vld_q       <= 1'b0;
      load_q      <= 1'b0;
      rd_q        <= '0;
      offset_q    <= '0;
      last_q      <= 1'b0;
      wb_vld_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_off_q    <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cmd_load_q  <= cmd_load_d;
      cmd_wb_q    <= cmd_wb_d;
      cmd_rn_q    <= cmd_rn_d;
      cmd_delta_q <= cmd_delta_d;
      busy_q      <= busy_d;
      vld_q       <= vld_d;
      load_q      <= load_d;
      rd_q        <= rd_d;
      offset_q    <= offset_d;
      last_q      <= last_d;
      wb_vld_q    <= wb_vld_d;
      wb_rd_q     <= wb_rd_d;
      wb_off_q    <= wb_off_d;
    end
  end

`ifdef LDM_SEQ_PCLOAD_EN
  logic pc_load_q, pc_load_d;

  // Follows the next beat bundle, so it holds and clears together with it.
  always_comb pc_load_d = vld_d && load_d && (rd_d == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) pc_load_q <= 1'b0;
    else     pc_load_q <= pc_load_d;
  end

  assign o_pc_load = pc_load_q;
`else
  assign o_pc_load = 1'b0;
`endif

  assign o_busy       = busy_q;
  assign o_vld        = vld_q;
  assign o_load       = load_q;
  assign o_rd_code    = rd_q;
  assign o_offset     = offset_q;
  assign o_last       = last_q;
  assign o_wb_vld     = wb_vld_q;
  assign o_wb_rd_code = wb_rd_q;
  assign o_wb_offset  = wb_off_q;

endmodule

// File: tb/tb_ldm_seq.sv
// tb_ldm_seq: randomized and directed LDM/STM sequences checked against a list-level reference model.
// Expected beats are queued when a start is issued; a negedge monitor compares every presented beat.
// Flush/reset aborts drop the outstanding expectations and check that all outputs clear.
module tb_ldm_seq;

  logic        clk = 1'b0;
  logic        rst, i_en, i_flush, i_start, i_load, i_pre, i_up, i_wb;
  logic [3:0]  i_rn_code;
  logic [15:0] i_reg_list;
  logic        o_busy, o_vld, o_load, o_last, o_wb_vld, o_pc_load;
  logic [3:0]  o_rd_code, o_wb_rd_code;
  logic [7:0]  o_offset, o_wb_offset;

  always #5 clk = ~clk;

`ifdef LDM_SEQ_PCLOAD_EN
  localparam bit PCEN = 1'b1;
`else
  localparam bit PCEN = 1'b0;
`endif

  ldm_seq dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_flush(i_flush), .i_start(i_start),
    .i_load(i_load), .i_pre(i_pre), .i_up(i_up), .i_wb(i_wb),
    .i_rn_code(i_rn_code), .i_reg_list(i_reg_list),
    .o_busy(o_busy), .o_vld(o_vld), .o_load(o_load), .o_rd_code(o_rd_code),
    .o_offset(o_offset), .o_last(o_last), .o_wb_vld(o_wb_vld),
    .o_wb_rd_code(o_wb_rd_code), .o_wb_offset(o_wb_offset), .o_pc_load(o_pc_load)
  );

  typedef struct {
    bit         wb;
    bit         ld;
    logic [3:0] rd;
    logic [7:0] off;
    bit         last;
    bit         pc;
    logic [3:0] rn;
  } beat_t;

  beat_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: registers in ascending order, address = start address + 4k.
  task automatic push_exp(input bit l, p, u, w, input logic [3:0] rn, input logic [15:0] list,
                          output int nbeats);
    int    regs[$];
    int    n, base;
    bit    wb_on;
    beat_t b;
    for (int r = 0; r < 16; r++) if (list[r]) regs.push_back(r);
    n = regs.size();
    nbeats = 0;
    if (n == 0) return;
    if (!p && u)      base = 0;
    else if (p && u)  base = 4;
    else if (!p)      base = 4 - 4 * n;
    else              base = -4 * n;
    for (int k = 0; k < n; k++) begin
      b.wb   = 1'b0;
      b.ld   = l;
      b.rd   = 4'(regs[k]);
      b.off  = 8'(base + 4 * k);
      b.last = (k == n - 1);
      b.pc   = PCEN && l && (regs[k] == 15);
      b.rn   = rn;
      exp_q.push_back(b);
    end
    wb_on = w && !(l && list[rn]);
    if (wb_on) begin
      b.wb   = 1'b1;
      b.ld   = 1'b0;
      b.rd   = '0;
      b.off  = u ? 8'(4 * n) : 8'(-4 * n);
      b.last = 1'b0;
      b.pc   = 1'b0;
      b.rn   = rn;
      exp_q.push_back(b);
    end
    nbeats = n + (wb_on ? 1 : 0);
  endtask

  // Monitor: compares whatever the DUT presents against the queue head; pops on consumption.
  beat_t e;
  always @(negedge clk) begin
    if (!rst && (o_vld || o_wb_vld)) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", {30'd0, o_vld, o_wb_vld}, 32'd0);
      end else begin
        e = exp_q[0];
        chk("beat_vld", o_vld, !e.wb);
        chk("beat_wb_vld", o_wb_vld, e.wb);
        chk("beat_busy", o_busy, 1);
        if (!e.wb) begin
          chk("rd_code", o_rd_code, e.rd);
          chk("offset", o_offset, e.off);
          chk("last", o_last, e.last);
          chk("load", o_load, e.ld);
          chk("pc_load", o_pc_load, e.pc);
        end else begin
          chk("wb_rd_code", o_wb_rd_code, e.rn);
          chk("wb_offset", o_wb_offset, e.off);
        end
        if (i_en && !i_flush) void'(exp_q.pop_front());
      end
    end else if (!rst) begin
      chk("idle_last_pc", {30'd0, o_last, o_pc_load}, 32'd0);
    end
  end

  task automatic check_cleared(input string nm);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_outs"}, {4'd0, o_vld, o_wb_vld, o_last, o_pc_load, o_load, o_rd_code, o_offset,
                        o_wb_offset, o_wb_rd_code}, 32'd0);
  endtask

  // Drives one instruction from the first IDLE cycle; hold_at = beat index to stall 2 cycles,
  // abort_at = beat index at which to flush (or reset); -1 disables either.
  task automatic run_seq(input bit l, p, u, w, input logic [3:0] rn, input logic [15:0] list,
                         input int stall_pct, input int hold_at, input int abort_at,
                         input bit abort_rst, input bit noise);
    int nb, used, cyc, hold_left;
    push_exp(l, p, u, w, rn, list, nb);
    i_start = 1'b1; i_en = 1'b1; i_load = l; i_pre = p; i_up = u; i_wb = w;
    i_rn_code = rn; i_reg_list = list;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_load = 1'($urandom); i_pre = 1'($urandom); i_up = 1'($urandom); i_wb = 1'($urandom);
    i_rn_code = 4'($urandom); i_reg_list = 16'($urandom);
    used = 0; cyc = 0; hold_left = 2;
    while (o_busy && cyc < 500) begin
      cyc++;
      i_start = noise ? 1'($urandom_range(1)) : 1'b0;
      if (used == abort_at) begin
        if (abort_rst) rst = 1'b1;
        else           i_flush = 1'b1;
        i_en = 1'($urandom_range(1));
        @(posedge clk); #1;
        rst = 1'b0; i_flush = 1'b0; i_start = 1'b0;
        exp_q.delete();
        check_cleared(abort_rst ? "after_rst" : "after_flush");
        return;
      end
      if (used == hold_at && hold_left > 0) begin
        i_en = 1'b0;
        hold_left--;
      end else begin
        i_en = ($urandom_range(99) >= stall_pct);
      end
      @(posedge clk); #1;
      if (i_en) used++;
    end
    i_start = 1'b0;
    i_en = 1'b1;
    chk("seq_timeout", (cyc < 500), 1);
    chk("beats_consumed", used, nb);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  logic [15:0] rl;
  initial begin
    rst = 1'b1; i_en = 1'b0; i_flush = 1'b0; i_start = 1'b0; i_load = 1'b0; i_pre = 1'b0;
    i_up = 1'b0; i_wb = 1'b0; i_rn_code = '0; i_reg_list = '0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // LDMIA R0!, {R1,R3}
    run_seq(1, 0, 1, 1, 4'd0, 16'h000A, 0, -1, -1, 0, 0);
    // STMDB R13!, {R4-R7}
    run_seq(0, 1, 0, 1, 4'd13, 16'h00F0, 0, -1, -1, 0, 0);
    // LDMIB R2!, {R2,R5}: base in list, no writeback
    run_seq(1, 1, 1, 1, 4'd2, 16'h0024, 0, -1, -1, 0, 0);
    // STMIA with 3 registers: stall on beat 1, flush on beat 2
    run_seq(0, 0, 1, 1, 4'd3, 16'h0111, 0, 0, 1, 0, 0);
    // Empty list with writeback
    run_seq(0, 0, 1, 1, 4'd4, 16'h0000, 0, -1, -1, 0, 0);
    chk("empty_no_busy", o_busy, 0);
    // Start with i_en low in IDLE is not taken
    i_start = 1'b1; i_en = 1'b0; i_reg_list = 16'h00FF; i_load = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_en = 1'b1;
    chk("start_en_low_busy", o_busy, 0);
    // Start pulses while busy must be ignored
    run_seq(1, 0, 0, 1, 4'd9, 16'h3C03, 20, -1, -1, 0, 1);
    // LDMIA R0, {R0,R15}
    run_seq(1, 0, 1, 0, 4'd0, 16'h8001, 0, -1, -1, 0, 0);
    // Reset mid-sequence
    run_seq(1, 0, 0, 1, 4'd5, 16'h0F0F, 0, -1, 2, 1, 0);
    // Back-to-back start right after the final beat
    run_seq(0, 1, 1, 0, 4'd1, 16'hFFFF, 0, -1, -1, 0, 0);
    run_seq(1, 0, 1, 1, 4'd14, 16'h8000, 0, -1, -1, 0, 0);

    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(9))
        0:       rl = 16'h0000;
        1:       rl = 16'hFFFF;
        2:       rl = 16'h1 << $urandom_range(15);
        default: rl = 16'($urandom);
      endcase
      run_seq(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), rl,
              $urandom_range(40), -1,
              ($urandom_range(9) == 0) ? int'($urandom_range(8)) : -1,
              1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ldm_seq.md
# ldm_seq

Block-transfer micro-sequencer between decode and the ID/EX pipeline register. It expands one LDM/STM instruction into one single-register transfer beat per cycle, plus an optional base-writeback beat. Each beat is a registered bundle that decode muxes onto the ID/EX inputs. While the sequencer runs it holds fetch/decode through `o_busy`.

## Interface
Parameters: none.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `i_en` input 1: ID/EX advance enable. Beats are consumed and the state advances only when this is high.
- `i_flush` input 1: synchronous abort (branch/IRQ flush).
- `i_start` input 1: decode has a valid LDM/STM this cycle. Sampled only in IDLE with `i_en` high.
- `i_load` input 1: L bit (1 = LDM).
- `i_pre` input 1: P bit.
- `i_up` input 1: U bit.
- `i_wb` input 1: W bit.
- `i_rn_code` input 4: base register.
- `i_reg_list` input 16: register list.
- `o_busy` output 1: sequencer not in IDLE; stalls fetch/decode.
- `o_vld` output 1: a transfer beat is presented.
- `o_load` output 1: beat is a load.
- `o_rd_code` output 4: transfer register.
- `o_offset` output 8: signed byte offset from the base for this beat.
- `o_last` output 1: final transfer beat.
- `o_wb_vld` output 1: writeback beat is presented.
- `o_wb_rd_code` output 4: equals `i_rn_code` (latched).
- `o_wb_offset` output 8: signed writeback delta, ±4·n.
- `o_pc_load` output 1: beat loads R15 (see Configuration).

## Operation
- States: IDLE, XFER, WB.
- IDLE, when `i_start` and `i_en` are both high:
  - Latch the list, L, P, U, W and Rn.
  - Compute n = popcount(list).
  - If n = 0: stay in IDLE. No beats are emitted and nothing is written back.
  - Otherwise go to XFER.
- Base offset (8-bit two's complement):
  - IA (P=0, U=1): 0.
  - IB (P=1, U=1): +4.
  - DA (P=0, U=0): −4n+4.
  - DB (P=1, U=0): −4n.
- XFER, one beat per cycle with `i_en` high:
  - `o_rd_code` is the lowest set bit of the remaining list. That bit is cleared when the beat is consumed.
  - `o_offset` = base + 4k, where k is the beat index starting at 0. Registers go out in ascending order at ascending addresses.
  - On the beat that empties the list, `o_last` = 1. The next state is WB if writeback is enabled, else IDLE.
- Writeback is enabled when W = 1, except for an LDM whose list contains Rn. In that case writeback is suppressed and the loaded value wins.
- WB, one cycle with `i_en` high:
  - `o_wb_vld` = 1, `o_vld` = 0.
  - `o_wb_offset` = +4n if U = 1, else −4n.
  - Next state is IDLE.
- `i_en` low: state, remaining list and all outputs hold.
- `i_flush`:
  - Has priority over `i_en`.
  - Next state is IDLE, and all outputs go to 0 on the next edge.
  - Any `i_start` in the same cycle is ignored.
- `i_start` outside IDLE: ignored.
- `rst`:
  - Has priority over everything, including mid-sequence.
  - All outputs reset to 0 and the state goes to IDLE.

## Timing
- All outputs are registered. The edge that samples `i_start` presents the first beat in the following cycle (latency 1).
- `o_busy` = (state ≠ IDLE), registered. It is high from the cycle after start through the cycle holding the final beat (last XFER, or WB).
- A sequence takes n beats, plus 1 if writeback is enabled, with `i_en` continuously high. Cycles with `i_en` low extend it one-for-one.
- Back-to-back LDM/STM: the next `i_start` can be accepted in the first IDLE cycle after the final beat.
- `o_vld`, `o_last`, `o_wb_vld` and `o_pc_load` are 0 in every cycle with no beat, including IDLE.

## Configuration
- Macro: `LDM_SEQ_PCLOAD_EN`.
- Defined: `o_pc_load` = 1 on the LDM beat whose `o_rd_code` = 15. Since R15 is always the last register in ascending order, this coincides with `o_last`.
- Undefined: `o_pc_load` is tied to 0 and the PC-load detection logic is not built. R15 loads still issue as ordinary beats.

## Test plan
- **LDMIA with writeback:** LDMIA R0!, {R1,R3} (list 0x000A, U=1, P=0, W=1) → beats (R1, +0) then (R3, +4, last), then WB with R0 and +8. `o_busy` is high for 3 cycles.
- **STMDB with writeback:** STMDB R13!, {R4–R7} (list 0x00F0) → offsets −16, −12, −8, −4, then WB with −16.
- **LDMIB with Rn in list:** LDMIB R2!, {R2,R5} → offsets +4, +8 and no WB beat.
- **Stall then flush:** STMIA with 3 registers, `i_en` low for 2 cycles during beat 1 → beat 1 outputs hold for those cycles. Then `i_flush` during beat 2 → IDLE on the next cycle, all outputs 0, and beat 3 is never emitted.
- **Empty list and ignored start:** empty list with W=1 → no beats and `o_busy` stays 0. An `i_start` asserted while busy is ignored.
- **PC load and reset:** LDMIA R0, {R0,R15} with the macro defined → `o_pc_load` = 1 only on the R15 beat (offset +4); with the macro undefined, `o_pc_load` stays 0. Asserting `rst` mid-sequence → all outputs 0 and IDLE on the next edge.
